// File: rtl/bram.sv
// Single-port synchronous block RAM with registered, read-first output.
// Define BRAM_OUT_REG_EN to add a second output register (2-cycle read latency).
module bram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  localparam int DEPTH = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  // Strobes: no valid/ready handshake. write_enable and read_enable are each
  // accepted on every rising clk edge where rst is low; there is never backpressure.

  // Zero initial contents become the FPGA bitstream init as well as the sim start value.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  // The array has no reset; rst only blocks writes.
  always_ff @(posedge clk) begin
    if (!rst && write_enable) begin
      mem[address] <= data_in;
    end
  end

`ifdef BRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] rd_q;

  // Both stages sample mem before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q     <= '0;
      data_out <= '0;
    end else begin
      if (read_enable) begin
        rd_q <= mem[address];
      end
      data_out <= rd_q;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (read_enable) begin
      data_out <= mem[address];
    end
  end
`endif

endmodule

// File: tb/tb_bram.sv
// Directed self-checking bench for bram; follows BRAM_OUT_REG_EN for read latency.
module tb_bram;

  localparam int DW = 8;
  localparam int AW = 4;
`ifdef BRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write_enable = 1'b0;
  logic          read_enable = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks: entered and left at a falling edge.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_enable = 1'b1;
    address = a;
    data_in = d;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    read_enable = 1'b1;
    address = a;
    @(negedge clk);
    read_enable = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check(tag, data_out, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_out", data_out, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Power-up contents
    do_read("unwritten_7", 4'd7, 8'h00);

    // Asynchronous reset with a nonzero output
    do_write(4'd4, 8'hA5);
    do_read("pre_reset", 4'd4, 8'hA5);
    #2 rst = 1'b1;
    #1 check("async_reset", data_out, 8'h00);
    @(negedge clk);
    write_enable = 1'b1;
    read_enable = 1'b1;
    address = 4'd8;
    data_in = 8'h99;
    @(negedge clk);
    check("reset_hold", data_out, 8'h00);
    write_enable = 1'b0;
    read_enable = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    do_read("write_blocked_in_rst", 4'd8, 8'h00);
    do_read("array_survives", 4'd4, 8'hA5);
    do_write(4'd2, 8'h3C);
    do_read("post_reset_rw", 4'd2, 8'h3C);

    // Fill with back-to-back writes, then streamed back-to-back reads
    for (int i = 0; i < 16; i++) do_write(i[AW-1:0], DW'(i + 1));
    for (int i = 0; i < 16 + LAT; i++) begin
      if (i >= LAT) check($sformatf("fill_%0d", i - LAT), data_out, exp_q.pop_front());
      if (i < 16) begin
        read_enable = 1'b1;
        address = i[AW-1:0];
        exp_q.push_back(DW'(i + 1));
      end else begin
        read_enable = 1'b0;
      end
      @(negedge clk);
    end

    // Boundary addresses
    do_write(4'd15, 8'hFF);
    do_write(4'd0, 8'h80);
    do_read("addr_15", 4'd15, 8'hFF);
    do_read("addr_0", 4'd0, 8'h80);

    // Read-first collision
    do_write(4'd5, 8'h11);
    write_enable = 1'b1;
    read_enable = 1'b1;
    address = 4'd5;
    data_in = 8'h22;
    @(negedge clk);
    write_enable = 1'b0;
    read_enable = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check("collision_old", data_out, 8'h11);
    do_read("collision_new", 4'd5, 8'h22);

    // Hold with read_enable low and a moving address
    do_write(4'd6, 8'h07);
    do_read("hold_src", 4'd6, 8'h07);
    address = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold_%0d", i), data_out, 8'h07);
    end

    // Write without read leaves the output alone
    do_write(4'd3, 8'h5A);
    repeat (LAT - 1) @(negedge clk);
    check("write_no_read", data_out, 8'h07);
    do_read("readback_3", 4'd3, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
